// File: rtl/dma_pkg.sv
// Shared types and default sizing for the DMA copy master.
package dma_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_LEN_W      = 16;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_STRIDE     = DEF_DATA_W / 8;

   // Byte distance between consecutive words on the bus.
   function automatic int byte_stride(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/dma_copy_fifo.sv
// Read-data buffer between the read and write masters. Show-ahead: o_dout
// always presents the oldest entry. Storage is reset so the head reads 0
// after reset.
module dma_copy_fifo
   import dma_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_push,
   input  logic [DATA_W-1:0]             i_din,
   input  logic                          i_pop,
   output logic [DATA_W-1:0]             o_dout,
   output logic [$clog2(FIFO_DEPTH):0]   o_used,
   output logic                          o_empty,
   output logic                          o_full
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_used;

   // Storage, pointers and occupancy; callers never push when full or pop when empty.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_used   <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({i_push, i_pop})
            2'b10:   r_used <= r_used + (AW+1)'(1);
            2'b01:   r_used <= r_used - (AW+1)'(1);
            default: r_used <= r_used;
         endcase
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_used  = r_used;
   assign o_empty = (r_used == '0);
   assign o_full  = (r_used == (AW+1)'(FIFO_DEPTH));

endmodule

// File: rtl/dma_copy_master.sv
// Block copy engine: a pipelined read master fills a small buffer, a write
// master drains it. Read issue is credit-limited so outstanding reads plus
// buffered words never exceed the buffer depth. All bus outputs are registered;
// their next values are computed from the next-cycle counters.
module dma_copy_master
   import dma_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LEN_W      = DEF_LEN_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [LEN_W-1:0]      length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     rd_address,
   output logic                  rd_read,
   input  logic                  rd_waitrequest,
   input  logic [DATA_W-1:0]     rd_readdata,
   input  logic                  rd_readdatavalid,
   output logic [ADDR_W-1:0]     wr_address,
   output logic                  wr_write,
   output logic [DATA_W-1:0]     wr_writedata,
   output logic [DATA_W/8-1:0]   wr_byteenable,
   input  logic                  wr_waitrequest
);

   localparam int                STRIDE = byte_stride(DATA_W);
   localparam int                CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] AMASK  = ~ADDR_W'(STRIDE - 1);

   state_t            r_state, w_state_nxt;
   logic [LEN_W-1:0]  r_rd_left, r_wr_left, w_rd_left_nxt, w_wr_left_nxt;
   logic [CW-1:0]     r_pending, w_pending_nxt, w_used, w_used_nxt;
   logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
   logic              r_rd_read, r_wr_write, r_busy, r_done;
   logic              w_rd_read_nxt, w_wr_write_nxt;
   logic              w_run, w_start, w_zero, w_rd_acc, w_wr_acc, w_rtn;
   logic              w_push, w_pop, w_last, w_empty, w_full;

   assign w_run    = (r_state == ST_RUN);
   assign w_start  = !w_run && go && (length != '0);
   assign w_zero   = !w_run && go && (length == '0);
   assign w_rd_acc = r_rd_read && !rd_waitrequest;
   assign w_wr_acc = r_wr_write && !wr_waitrequest;
   // Returns outside RUN are stale beats from before a reset.
   assign w_rtn    = w_run && rd_readdatavalid;
   assign w_push   = w_rtn && !w_full;
   assign w_pop    = w_wr_acc && !w_empty;
   assign w_last   = w_wr_acc && (r_wr_left == LEN_W'(1));

   dma_copy_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_push),
      .i_din   (rd_readdata),
      .i_pop   (w_pop),
      .o_dout  (wr_writedata),
      .o_used  (w_used),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and next values of counters and registered request outputs.
   always_comb begin
      w_state_nxt   = r_state;
      w_rd_left_nxt = r_rd_left;
      w_wr_left_nxt = r_wr_left;
      w_pending_nxt = r_pending;
      w_used_nxt    = w_used;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last)  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_start) begin
         w_rd_left_nxt = length;
         w_wr_left_nxt = length;
         w_pending_nxt = '0;
      end else begin
         if (w_rd_acc) w_rd_left_nxt = r_rd_left - LEN_W'(1);
         if (w_wr_acc) w_wr_left_nxt = r_wr_left - LEN_W'(1);
         case ({w_rd_acc, w_rtn})
            2'b10:   w_pending_nxt = r_pending + CW'(1);
            2'b01:   w_pending_nxt = r_pending - CW'(1);
            default: w_pending_nxt = r_pending;
         endcase
      end
      case ({w_push, w_pop})
         2'b10:   w_used_nxt = w_used + CW'(1);
         2'b01:   w_used_nxt = w_used - CW'(1);
         default: w_used_nxt = w_used;
      endcase
      w_rd_read_nxt  = (w_state_nxt == ST_RUN) && (w_rd_left_nxt != '0) &&
                       (({1'b0, w_pending_nxt} + {1'b0, w_used_nxt}) < (CW+1)'(FIFO_DEPTH));
      w_wr_write_nxt = (w_state_nxt == ST_RUN) && (w_used_nxt != '0);
   end

   // Counters, address generators and registered status/request outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_left  <= '0;
         r_wr_left  <= '0;
         r_pending  <= '0;
         r_rd_addr  <= '0;
         r_wr_addr  <= '0;
         r_rd_read  <= 1'b0;
         r_wr_write <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_rd_left  <= w_rd_left_nxt;
         r_wr_left  <= w_wr_left_nxt;
         r_pending  <= w_pending_nxt;
         r_rd_read  <= w_rd_read_nxt;
         r_wr_write <= w_wr_write_nxt;
         r_busy     <= (w_state_nxt == ST_RUN);
         r_done     <= w_last || w_zero;
         if (w_start) begin
            r_rd_addr <= src_addr & AMASK;
            r_wr_addr <= dst_addr & AMASK;
         end else begin
            if (w_rd_acc) r_rd_addr <= r_rd_addr + ADDR_W'(STRIDE);
            if (w_wr_acc) r_wr_addr <= r_wr_addr + ADDR_W'(STRIDE);
         end
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign rd_read       = r_rd_read;
   assign rd_address    = r_rd_addr;
   assign wr_write      = r_wr_write;
   assign wr_address    = r_wr_addr;
   assign wr_byteenable = {(DATA_W/8){r_wr_write}};

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master: a latency-1 memory responder with
// programmable stalls, a write scoreboard and hand-computed timing checks.
module tb_dma_copy_master;

   logic        clk = 1'b0;
   logic        reset, go;
   logic [31:0] src_addr, dst_addr;
   logic [15:0] length;
   logic        busy, done, rd_read, rd_waitrequest, rd_readdatavalid;
   logic [31:0] rd_address, rd_readdata, wr_address, wr_writedata;
   logic        wr_write, wr_waitrequest;
   logic [3:0]  wr_byteenable;

   dma_copy_master dut (
      .clk              (clk),
      .reset            (reset),
      .go               (go),
      .src_addr         (src_addr),
      .dst_addr         (dst_addr),
      .length           (length),
      .busy             (busy),
      .done             (done),
      .rd_address       (rd_address),
      .rd_read          (rd_read),
      .rd_waitrequest   (rd_waitrequest),
      .rd_readdata      (rd_readdata),
      .rd_readdatavalid (rd_readdatavalid),
      .wr_address       (wr_address),
      .wr_write         (wr_write),
      .wr_writedata     (wr_writedata),
      .wr_byteenable    (wr_byteenable),
      .wr_waitrequest   (wr_waitrequest)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_q [$];
   int          n_chk = 0, n_err = 0;
   int          cyc, done_cyc, done_cnt, first_wr, rd_cnt, wr_cnt;
   int          wr_mode, wr_hold_until, stall_idx, stall_left;
   bit          rd_seen, wr_seen, rd_hold, wr_hold, rv_vld, stale;
   logic [31:0] rv_data, hold_ra, hold_wa, hold_wd, exp_ra, exp_wa;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rdmem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Record what the DUT shows in the current cycle.
   task automatic observe();
      if (done) begin
         done_cnt++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      if (rd_read) rd_seen = 1'b1;
      if (wr_write) begin
         wr_seen = 1'b1;
         if (first_wr < 0) first_wr = cyc;
      end
      if (rd_hold) chk("rd_hold", {rd_read, rd_address}, {1'b1, hold_ra});
      if (wr_hold) chk("wr_hold", {wr_write, wr_address, wr_writedata}, {1'b1, hold_wa, hold_wd});
   endtask

   // Drive the responder for one cycle, score accepted transfers, advance.
   task automatic bus_cycle();
      bit          ra, wa;
      logic [31:0] nd, e;
      nd = 32'h0;
      rd_waitrequest = 1'b0;
      if (rd_read && rd_cnt == stall_idx && stall_left > 0) begin
         rd_waitrequest = 1'b1;
         stall_left--;
      end
      case (wr_mode)
         1:       wr_waitrequest = cyc[0];
         2:       wr_waitrequest = (cyc < wr_hold_until);
         default: wr_waitrequest = 1'b0;
      endcase
      rd_readdatavalid = rv_vld | stale;
      rd_readdata      = stale ? 32'hDEADBEEF : rv_data;
      stale = 1'b0;
      ra = rd_read && !rd_waitrequest;
      wa = wr_write && !wr_waitrequest;
      rd_hold = rd_read && rd_waitrequest;
      wr_hold = wr_write && wr_waitrequest;
      hold_ra = rd_address;
      hold_wa = wr_address;
      hold_wd = wr_writedata;
      if (ra) begin
         chk("rd_addr", rd_address, exp_ra);
         exp_ra += 32'd4;
         nd = rdmem(rd_address);
         rd_cnt++;
      end
      if (wa) begin
         chk("wr_addr", wr_address, exp_wa);
         chk("wr_be", wr_byteenable, 4'hF);
         exp_wa += 32'd4;
         if (exp_q.size() == 0) chk("wr_extra", wr_writedata, 32'hx);
         else begin
            e = exp_q.pop_front();
            chk("wr_data", wr_writedata, e);
         end
         mem[wr_address] = wr_writedata;
         wr_cnt++;
      end
      @(negedge clk);
      cyc++;
      rv_vld  = ra;
      rv_data = nd;
      observe();
   endtask

   // Present a command in cycle 0 and step into cycle 1.
   task automatic start(input logic [31:0] s, input logic [31:0] d, input int len);
      cyc = 0; done_cyc = -1; done_cnt = 0; first_wr = -1;
      rd_cnt = 0; wr_cnt = 0; rd_seen = 0; wr_seen = 0;
      exp_ra = s & 32'hFFFF_FFFC;
      exp_wa = d & 32'hFFFF_FFFC;
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(rdmem(exp_ra + 32'(4 * i)));
      src_addr = s; dst_addr = d; length = 16'(len); go = 1'b1;
      bus_cycle();
      go = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cyc < 0 && n < budget) begin
         bus_cycle();
         n++;
      end
      chk({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      rd_waitrequest = 1'b0; rd_readdata = '0; rd_readdatavalid = 1'b0; wr_waitrequest = 1'b0;
      wr_mode = 0; wr_hold_until = 0; stall_idx = -1; stall_left = 0;
      rv_vld = 0; rv_data = '0; stale = 0; rd_hold = 0; wr_hold = 0; cyc = 0;
      for (int i = 0; i < 4; i++)  mem[32'(4 * i)]         = 32'h1111_1111 * 32'(i + 1);
      for (int i = 0; i < 20; i++) mem[32'h100 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
      for (int i = 0; i < 10; i++) mem[32'h300 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);

      // Reset values.
      repeat (2) @(negedge clk);
      chk("rst_outputs", {busy, done, rd_read, wr_write, wr_byteenable, rd_address, wr_address, wr_writedata}, '0);
      reset = 1'b0;
      @(negedge clk);

      // Basic copy, zero-wait.
      start(32'h0, 32'h4000, 4);
      chk("basic_busy_c1", {busy, rd_read}, 2'b11);
      run_until_done("basic", 40);
      chk("basic_done_cyc", done_cyc, 7);
      chk("basic_first_wr", first_wr, 3);
      chk("basic_busy_at_done", busy, 1'b0);
      chk("basic_mem0", rdmem(32'h4000), 32'h1111_1111);
      chk("basic_mem1", rdmem(32'h4004), 32'h2222_2222);
      chk("basic_mem2", rdmem(32'h4008), 32'h3333_3333);
      chk("basic_mem3", rdmem(32'h400C), 32'h4444_4444);
      repeat (2) bus_cycle();

      // Back-pressure on both masters.
      for (int i = 0; i < 4; i++) mem.delete(32'h4000 + 32'(4 * i));
      stall_idx = 1; stall_left = 3; wr_mode = 1;
      start(32'h0, 32'h4000, 4);
      run_until_done("bp", 60);
      chk("bp_rd_cnt", rd_cnt, 4);
      chk("bp_wr_cnt", wr_cnt, 4);
      chk("bp_mem3", rdmem(32'h400C), 32'h4444_4444);
      stall_idx = -1; wr_mode = 0;
      repeat (2) bus_cycle();

      // Credit limit: writes held off, reads must stop at the buffer depth.
      wr_mode = 2; wr_hold_until = 30;
      start(32'h100, 32'h5000, 20);
      while (cyc < 29) bus_cycle();
      chk("credit_rd_cnt", rd_cnt, 8);
      chk("credit_rd_read", rd_read, 1'b0);
      chk("credit_wr_cnt", wr_cnt, 0);
      run_until_done("credit", 200);
      chk("credit_wr_total", wr_cnt, 20);
      chk("credit_mem_first", rdmem(32'h5000), 32'hA000_0000);
      chk("credit_mem_last", rdmem(32'h504C), 32'hA000_0013);
      wr_mode = 0;
      repeat (2) bus_cycle();

      // Zero length.
      start(32'h10, 32'h20, 0);
      chk("zero_done_c1", {done, busy}, 2'b10);
      repeat (4) bus_cycle();
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_no_bus", {rd_seen, wr_seen}, 2'b00);

      // Misaligned addresses and a go pulse while busy.
      start(32'h3, 32'h6002, 3);
      chk("misal_rd_addr", rd_address, 32'h0);
      go = 1'b1; length = 16'd5; src_addr = 32'h200;
      bus_cycle();
      go = 1'b0;
      run_until_done("misal", 40);
      chk("misal_done_cyc", done_cyc, 6);
      chk("misal_cnts", {rd_cnt[7:0], wr_cnt[7:0]}, {8'd3, 8'd3});
      chk("misal_mem2", rdmem(32'h6008), 32'h3333_3333);
      repeat (3) bus_cycle();
      chk("misal_idle", {done_cnt[3:0], busy, rd_read}, {4'd1, 2'b00});

      // Reset in the middle of a copy, then a stale return, then a new copy.
      start(32'h300, 32'h7000, 10);
      for (int n = 0; n < 100 && wr_cnt < 5; n++) bus_cycle();
      chk("rst_mid_progress", wr_cnt, 5);
      reset = 1'b1;
      #1;
      chk("rst_mid_outputs", {busy, done, rd_read, wr_write, wr_byteenable, rd_address, wr_address, wr_writedata}, '0);
      exp_q.delete(); rv_vld = 0; rd_hold = 0; wr_hold = 0;
      @(negedge clk);
      reset = 1'b0;
      rd_seen = 0; wr_seen = 0; stale = 1'b1;
      repeat (4) bus_cycle();
      chk("rst_stale_quiet", {rd_seen, wr_seen, busy}, 3'b000);
      start(32'h0, 32'h7100, 2);
      run_until_done("rst_new", 40);
      chk("rst_new_done_cyc", done_cyc, 5);
      chk("rst_new_mem0", rdmem(32'h7100), 32'h1111_1111);
      chk("rst_new_mem1", rdmem(32'h7104), 32'h2222_2222);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dma_copy_master.md
# dma_copy_master

Avalon-MM dual-master copy engine that moves a block of 32-bit words from a source region to a destination region, both typically in on-chip RAM. It drives the read and write ports of the memory responders from the initiator side: pipelined reads with `waitrequest`/`readdatavalid`, write-backs with `waitrequest`. A command (`go`, `src_addr`, `dst_addr`, `length`) comes from the Nios II CSR glue, and the block reports completion with `busy`/`done`.

## Interface
- `ADDR_W`, 32, byte-address width of both master ports
- `DATA_W`, 32, data width; the byte stride is DATA_W/8
- `LEN_W`, 16, width of the word count
- `FIFO_DEPTH`, 8, depth of the read-data buffer; power of two, ≥2
- `clk`  in  1  single clock for all logic
- `reset`  in  1  asynchronous, active-high reset
- `go`  in  1  starts a copy; sampled only in IDLE
- `src_addr`  in  ADDR_W  source byte address; low log2(DATA_W/8) bits are forced to 0
- `dst_addr`  in  ADDR_W  destination byte address; alignment handled as for src_addr
- `length`  in  LEN_W  number of words to copy
- `busy`  out  1  high from the cycle after an accepted `go` until completion
- `done`  out  1  one-cycle pulse on completion
- `rd_address`  out  ADDR_W  read master address
- `rd_read`  out  1  read request
- `rd_waitrequest`  in  1  read stall
- `rd_readdata`  in  DATA_W  read data
- `rd_readdatavalid`  in  1  read data valid
- `wr_address`  out  ADDR_W  write master address
- `wr_write`  out  1  write request
- `wr_writedata`  out  DATA_W  write data (FIFO head)
- `wr_byteenable`  out  DATA_W/8  all ones while `wr_write` is high, 0 otherwise
- `wr_waitrequest`  in  1  write stall

## Operation
- States: IDLE and RUN.
- IDLE → RUN when `go` is high and `length`≠0. Latch the aligned addresses, and load `rd_left` and `wr_left` with `length`.
- `go` with `length`=0 in IDLE: pulse `done` the next cycle. No bus activity; `busy` stays low.
- `go` in RUN is ignored. Command inputs are don't-care outside the accepting cycle.
- Read issue: `rd_read` = RUN & `rd_left`≠0 & (`pending` + `fifo_used`) < FIFO_DEPTH.
  - A read is accepted when `rd_read` & !`rd_waitrequest`. On acceptance: `rd_address` += DATA_W/8, `rd_left`−1, `pending`+1.
  - While `rd_waitrequest` is high, `rd_read` and `rd_address` hold stable.
- Read return: `rd_readdatavalid` pushes `rd_readdata` into the FIFO and decrements `pending`.
  - The credit rule guarantees no overflow. `rd_readdatavalid` is ignored in IDLE.
  - If issue and return happen in the same cycle, `pending` is unchanged.
- Write: `wr_write` = RUN & FIFO not empty. The write is accepted when !`wr_waitrequest`. On acceptance: pop the FIFO, `wr_address` += DATA_W/8, `wr_left`−1.
  - While stalled, address and data hold stable.
- RUN → IDLE on acceptance of the final write (`wr_left`=1). `done` pulses and `busy` falls in the following cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Overlapping regions are not detected. Forward-copy semantics apply.
- Reset, including mid-operation: go to IDLE, clear `pending`, empty the FIFO, drive all outputs to 0.
  - Stale `readdatavalid` beats that arrive after reset are dropped because the state is IDLE.

## Timing
- Reset values: `busy`, `done`, `rd_read`, `wr_write`, `wr_byteenable`, `rd_address`, `wr_address`, `wr_writedata` are all 0.
- `go` in cycle 0 → `busy` and `rd_read` high in cycle 1.
- With a zero-wait, latency-1 responder:
  - first `readdatavalid` in cycle 2;
  - first `wr_write` in cycle 3 (FIFO output is registered and show-ahead).
- Steady-state throughput is 1 word/cycle with no stalls. For N words, the last write is in cycle N+2 and `done` is in cycle N+3.
- Every output is driven from a register. There are no combinational paths from `*_waitrequest` to the request outputs other than hold logic.

## Structure
- Package `dma_pkg`: state enum (`ST_IDLE`, `ST_RUN`), default widths, and byte-stride constant.
- Sub-module `dma_copy_fifo`: synchronous show-ahead FIFO with outputs `used`, `empty`, `full`, parameterized by DATA_W and FIFO_DEPTH. The top level holds the FSM, counters, and address generators.

## Test plan
- Basic copy: src=0x0000, dst=0x4000, length=4, source words 0x11111111…0x44444444, zero-wait responder → destination holds the same four words at 0x4000–0x400C; `done` in cycle 7.
- Back-pressure: same copy with `rd_waitrequest` high for 3 cycles on the 2nd read and `wr_waitrequest` high on alternate cycles → correct data; addresses and data stable during stalls; exactly 4 reads and 4 writes accepted.
- Credit limit: length=20, FIFO_DEPTH=8, `wr_waitrequest` held high for 30 cycles → `rd_read` stops after 8 accepted reads; all 20 words arrive in order after release.
- Zero length: `go` with length=0 → `done` pulses in cycle 1; no `rd_read` or `wr_write` ever asserted.
- Busy ignore and misalignment: `go` pulsed again mid-copy → ignored; src=0x0003 → first `rd_address`=0x0000.
- Reset mid-copy: assert `reset` after 5 of 10 words, deliver a stale `readdatavalid` → all outputs 0; no write issued; a new copy of length=2 completes correctly.
